jtopl_eg_slot_seq: RTL and testbench

Time-multiplexing controller for the envelope final-attenuation stage. It holds the per-operator TL/KSL/AM-select/keycode settings for 18 slots and walks a slot counter on every clock enable. It presents the current slot's settings and the AM LFO value to the attenuation datapath, then registers the limited result tagged with its slot. Sits between the register interface (writer side) and the EG/operator pipeline.

---
 rtl/jtopl_eg_slot_seq_pkg.sv | 20 ++
 rtl/jtopl_eg_am_lfo.sv | 35 +++
 rtl/jtopl_eg_slot_seq.sv | 109 ++++++++++
 tb/tb_jtopl_eg_slot_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_eg_slot_seq_pkg.sv
// Shared types and constants for the envelope final-attenuation slot sequencer.
// The per-slot setting record is kept packed so storage and output registers share one type.
package jtopl_eg_slot_seq_pkg;

  localparam int SLOTS_DEF = 18;
  localparam int SLOT_W    = 5;

  localparam logic [5:0] TL_RST = 6'h3f;
  localparam logic [9:0] EG_MAX = 10'h3ff;

  typedef struct packed {
    logic [5:0] tl;
    logic [1:0] ksl;
    logic       ams;
    logic [3:0] kc;
  } slot_cfg_t;

  localparam slot_cfg_t CFG_RST = '{tl: TL_RST, ksl: 2'd0, ams: 1'b0, kc: 4'd0};

endpackage

// File: rtl/jtopl_eg_am_lfo.sv
// AM LFO phase counter: advances once every AM_DIV slot rounds.
// i_hold parks both the phase and the round divider at zero.
module jtopl_eg_am_lfo #(
  parameter int AM_DIV = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_step,
  input  logic       i_hold,
  output logic [6:0] o_lfo_mod
);

  logic [7:0] r_div;
  logic [6:0] r_lfo_mod;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div     <= 8'd0;
      r_lfo_mod <= 7'd0;
    end else if (i_hold) begin
      r_div     <= 8'd0;
      r_lfo_mod <= 7'd0;
    end else if (i_step) begin
      if (r_div == 8'(AM_DIV - 1)) begin
        r_div     <= 8'd0;
        r_lfo_mod <= r_lfo_mod + 7'd1;
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  assign o_lfo_mod = r_lfo_mod;

endmodule

// File: rtl/jtopl_eg_slot_seq.sv
// Slot sequencer for the envelope attenuation stage: per-slot settings storage,
// slot counter, setting presentation with write-through, and the tagged result register.
module jtopl_eg_slot_seq
  import jtopl_eg_slot_seq_pkg::*;
#(
  parameter int SLOTS  = SLOTS_DEF,
  parameter int AM_DIV = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cen,
  input  logic              i_cfg_we,
  input  logic [SLOT_W-1:0] i_cfg_slot,
  input  logic [5:0]        i_cfg_tl,
  input  logic [1:0]        i_cfg_ksl,
  input  logic              i_cfg_ams,
  input  logic [3:0]        i_cfg_kc,
  input  logic              i_amsen,
  input  logic              i_am_hold,
  input  logic [9:0]        i_eg_pure_in,
  input  logic [9:0]        i_eg_limited,
  output logic [SLOT_W-1:0] o_cur_slot,
  output logic [5:0]        o_tl,
  output logic [1:0]        o_ksl,
  output logic              o_ams,
  output logic [3:0]        o_keycode,
  output logic              o_amsen,
  output logic [6:0]        o_lfo_mod,
  output logic [9:0]        o_eg_out,
  output logic [SLOT_W-1:0] o_eg_out_slot,
  output logic              o_eg_out_vld,
  output logic              o_round_start
);

  slot_cfg_t         r_mem [SLOTS];
  slot_cfg_t         r_cfg;
  logic [SLOT_W-1:0] r_cur_slot;
  logic [9:0]        r_eg_out;
  logic [SLOT_W-1:0] r_eg_out_slot;
  logic              r_eg_out_vld;

  slot_cfg_t         w_wr_cfg;
  slot_cfg_t         w_load_cfg;
  logic              w_wr_en;
  logic              w_last;
  logic [SLOT_W-1:0] w_next_slot;
  logic              w_lfo_step;
  logic              w_unused;

  // eg_pure_in is consumed by the datapath; it is only carried here for slot alignment
  assign w_unused = ^i_eg_pure_in;

  assign w_wr_cfg    = '{tl: i_cfg_tl, ksl: i_cfg_ksl, ams: i_cfg_ams, kc: i_cfg_kc};
  assign w_wr_en     = i_cfg_we && (i_cfg_slot < SLOT_W'(SLOTS));
  assign w_last      = (r_cur_slot == SLOT_W'(SLOTS - 1));
  assign w_next_slot = w_last ? '0 : r_cur_slot + 1'b1;
  assign w_lfo_step  = i_cen && w_last;

  // A write landing on the slot being loaded this edge is forwarded straight to the outputs
  assign w_load_cfg = (w_wr_en && (i_cfg_slot == w_next_slot)) ? w_wr_cfg : r_mem[w_next_slot];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_mem[i] <= CFG_RST;
      end
    end else if (w_wr_en) begin
      r_mem[i_cfg_slot] <= w_wr_cfg;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cur_slot    <= '0;
      r_cfg         <= CFG_RST;
      r_eg_out      <= EG_MAX;
      r_eg_out_slot <= '0;
      r_eg_out_vld  <= 1'b0;
    end else if (i_cen) begin
      r_cur_slot    <= w_next_slot;
      r_cfg         <= w_load_cfg;
      r_eg_out      <= i_eg_limited;
      r_eg_out_slot <= r_cur_slot;
      r_eg_out_vld  <= 1'b1;
    end
  end

  jtopl_eg_am_lfo #(
    .AM_DIV (AM_DIV)
  ) u_am_lfo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_step    (w_lfo_step),
    .i_hold    (i_am_hold),
    .o_lfo_mod (o_lfo_mod)
  );

  assign o_cur_slot    = r_cur_slot;
  assign o_tl          = r_cfg.tl;
  assign o_ksl         = r_cfg.ksl;
  assign o_ams         = r_cfg.ams;
  assign o_keycode     = r_cfg.kc;
  assign o_amsen       = i_amsen;
  assign o_eg_out      = r_eg_out;
  assign o_eg_out_slot = r_eg_out_slot;
  assign o_eg_out_vld  = r_eg_out_vld;
  assign o_round_start = (r_cur_slot == '0);

endmodule

// File: tb/tb_jtopl_eg_slot_seq.sv
// Self-checking bench for jtopl_eg_slot_seq: vector table for the first rounds,
// then hand-written sequences for hold, mid-round reset, AM LFO stepping and am_hold.
module tb_jtopl_eg_slot_seq;
  import jtopl_eg_slot_seq_pkg::*;

  localparam int NS  = SLOTS_DEF;
  localparam int AMD = 2;
  localparam int NV  = 61;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_slot = 5'd0;
  logic [5:0] cfg_tl = 6'd0;
  logic [1:0] cfg_ksl = 2'd0;
  logic       cfg_ams = 1'b0;
  logic [3:0] cfg_kc = 4'd0;
  logic       amsen = 1'b0;
  logic       am_hold = 1'b0;
  logic [9:0] eg_pure_in = 10'd0;
  logic [9:0] eg_limited = 10'd0;

  logic [4:0] o_cur_slot;
  logic [5:0] o_tl;
  logic [1:0] o_ksl;
  logic       o_ams;
  logic [3:0] o_keycode;
  logic       o_amsen;
  logic [6:0] o_lfo_mod;
  logic [9:0] o_eg_out;
  logic [4:0] o_eg_out_slot;
  logic       o_eg_out_vld;
  logic       o_round_start;

  always #5 clk = ~clk;

  jtopl_eg_slot_seq #(
    .SLOTS  (NS),
    .AM_DIV (AMD)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cen         (cen),
    .i_cfg_we      (cfg_we),
    .i_cfg_slot    (cfg_slot),
    .i_cfg_tl      (cfg_tl),
    .i_cfg_ksl     (cfg_ksl),
    .i_cfg_ams     (cfg_ams),
    .i_cfg_kc      (cfg_kc),
    .i_amsen       (amsen),
    .i_am_hold     (am_hold),
    .i_eg_pure_in  (eg_pure_in),
    .i_eg_limited  (eg_limited),
    .o_cur_slot    (o_cur_slot),
    .o_tl          (o_tl),
    .o_ksl         (o_ksl),
    .o_ams         (o_ams),
    .o_keycode     (o_keycode),
    .o_amsen       (o_amsen),
    .o_lfo_mod     (o_lfo_mod),
    .o_eg_out      (o_eg_out),
    .o_eg_out_slot (o_eg_out_slot),
    .o_eg_out_vld  (o_eg_out_vld),
    .o_round_start (o_round_start)
  );

  typedef struct {
    bit         we;
    logic [4:0] slot;
    slot_cfg_t  cfg;
    logic [9:0] eg_lim;
    logic [4:0] exp_slot;
    slot_cfg_t  exp_cfg;
  } vec_t;

  typedef struct packed {
    logic [9:0] eg;
    logic [4:0] slot;
  } sb_t;

  int         n_vec = 0;
  int         n_err = 0;
  vec_t       vecs [NV];
  sb_t        sb_q [$];
  slot_cfg_t  m_mem [NS];
  slot_cfg_t  m_cur;
  logic [4:0] m_slot;
  logic [9:0] m_eg_last;
  logic [4:0] m_eg_slot_last;

  function automatic slot_cfg_t mk(input int tl, input int ksl, input int ams, input int kc);
    slot_cfg_t c;
    c.tl  = 6'(tl);
    c.ksl = 2'(ksl);
    c.ams = 1'(ams);
    c.kc  = 4'(kc);
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_cfg(input string name, input slot_cfg_t e);
    chk({name, "_tl"},  32'(o_tl),      32'(e.tl));
    chk({name, "_ksl"}, 32'(o_ksl),     32'(e.ksl));
    chk({name, "_ams"}, 32'(o_ams),     32'(e.ams));
    chk({name, "_kc"},  32'(o_keycode), 32'(e.kc));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_mem[i] = CFG_RST;
    m_cur          = CFG_RST;
    m_slot         = 5'd0;
    m_eg_last      = EG_MAX;
    m_eg_slot_last = 5'd0;
    sb_q.delete();
  endtask

  task automatic drive_cfg(input bit we, input logic [4:0] slot, input slot_cfg_t c);
    cfg_we   = we;
    cfg_slot = slot;
    cfg_tl   = c.tl;
    cfg_ksl  = c.ksl;
    cfg_ams  = c.ams;
    cfg_kc   = c.kc;
    if (we && (int'(slot) < NS)) m_mem[slot] = c;
  endtask

  // One cen edge: the result tagged with the slot being left is queued, then checked after the edge
  task automatic step(input bit we, input logic [4:0] slot, input slot_cfg_t c, input logic [9:0] eg_lim);
    sb_t e;
    drive_cfg(we, slot, c);
    eg_limited = eg_lim;
    eg_pure_in = ~eg_lim;
    cen        = 1'b1;
    sb_q.push_back('{eg: eg_lim, slot: m_slot});
    m_slot = (int'(m_slot) == NS - 1) ? 5'd0 : 5'(m_slot + 5'd1);
    m_cur  = m_mem[m_slot];
    @(posedge clk);
    #1;
    cen    = 1'b0;
    cfg_we = 1'b0;
    chk("cur_slot", 32'(o_cur_slot), 32'(m_slot));
    chk_cfg("cfg", m_cur);
    chk("round_start", 32'(o_round_start), 32'(m_slot == 5'd0));
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: queue empty, expected one pending result");
    end else begin
      e = sb_q.pop_front();
      m_eg_last      = e.eg;
      m_eg_slot_last = e.slot;
      chk("eg_out",      32'(o_eg_out),      32'(e.eg));
      chk("eg_out_slot", 32'(o_eg_out_slot), 32'(e.slot));
      chk("eg_out_vld",  32'(o_eg_out_vld),  32'd1);
    end
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, CFG_RST, 10'($urandom_range(0, 1023)));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_cur_slot"},    32'(o_cur_slot),    32'd0);
    chk_cfg(name, CFG_RST);
    chk({name, "_lfo"},         32'(o_lfo_mod),     32'd0);
    chk({name, "_eg_out"},      32'(o_eg_out),      32'(EG_MAX));
    chk({name, "_eg_out_slot"}, 32'(o_eg_out_slot), 32'd0);
    chk({name, "_eg_out_vld"},  32'(o_eg_out_vld),  32'd0);
    chk({name, "_round_start"}, 32'(o_round_start), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int rs_cnt;

    // Vector table: round 1 idle, write slot 5, collision on slot 5, out-of-range writes, readback round
    for (int i = 0; i < NV; i++) begin
      vecs[i].we       = 1'b0;
      vecs[i].slot     = 5'd0;
      vecs[i].cfg      = CFG_RST;
      vecs[i].eg_lim   = 10'((i * 37 + 5) % 1024);
      vecs[i].exp_slot = 5'((i + 1) % NS);
      vecs[i].exp_cfg  = CFG_RST;
    end
    vecs[18].we = 1'b1; vecs[18].slot = 5'd5; vecs[18].cfg = mk(10, 2, 1, 9);
    vecs[22].exp_cfg = mk(10, 2, 1, 9);
    vecs[23].eg_lim  = 10'h123;
    vecs[40].we = 1'b1; vecs[40].slot = 5'd5; vecs[40].cfg = mk(20, 1, 0, 3);
    vecs[40].exp_cfg = mk(20, 1, 0, 3);
    vecs[41].we = 1'b1; vecs[41].slot = 5'd18; vecs[41].cfg = mk(0, 3, 1, 15);
    vecs[42].we = 1'b1; vecs[42].slot = 5'd31; vecs[42].cfg = mk(1, 3, 1, 14);
    vecs[58].exp_cfg = mk(20, 1, 0, 3);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    $display("reset released: cur_slot=%0d tl=%0d eg_out=%h vld=%0d", o_cur_slot, o_tl, o_eg_out, o_eg_out_vld);

    rs_cnt = 0;
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].we, vecs[i].slot, vecs[i].cfg, vecs[i].eg_lim);
      chk("tbl_slot", 32'(o_cur_slot), 32'(vecs[i].exp_slot));
      chk_cfg("tbl_cfg", vecs[i].exp_cfg);
      if (i < NS && o_round_start) rs_cnt++;
      if (i == 23) begin
        chk("tbl_eg_123",      32'(o_eg_out),      32'h123);
        chk("tbl_eg_123_slot", 32'(o_eg_out_slot), 32'd5);
      end
      $display("vec %0d: we=%0d slot=%0d -> cur_slot=%0d tl=%0d ksl=%0d ams=%0d kc=%0d eg_out=%h/%0d",
               i, vecs[i].we, vecs[i].slot, o_cur_slot, o_tl, o_ksl, o_ams, o_keycode,
               o_eg_out, o_eg_out_slot);
    end
    chk("round_start_count", 32'(rs_cnt), 32'd1);

    // cen held low: writes land in storage, outputs frozen, including a write to the presented slot
    for (int k = 0; k < 10; k++) begin
      drive_cfg(1'b1, 5'(k), mk(30 + k, k, k, k));
      eg_limited = 10'($urandom_range(0, 1023));
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      chk("hold_cur_slot", 32'(o_cur_slot), 32'(m_slot));
      chk_cfg("hold_cfg", m_cur);
      chk("hold_eg_out",      32'(o_eg_out),      32'(m_eg_last));
      chk("hold_eg_out_slot", 32'(o_eg_out_slot), 32'(m_eg_slot_last));
      $display("hold clk %0d: wrote slot %0d, cur_slot=%0d tl=%0d", k, k, o_cur_slot, o_tl);
    end
    run_steps(NS);
    $display("after hold round: cur_slot=%0d tl=%0d", o_cur_slot, o_tl);

    amsen = 1'b1;
    #1;
    chk("amsen_hi", 32'(o_amsen), 32'd1);
    amsen = 1'b0;
    #1;
    chk("amsen_lo", 32'(o_amsen), 32'd0);

    // Mid-round asynchronous reset wipes storage; first cen after release presents slot 1
    run_steps(3);
    rst = 1'b1;
    #1;
    chk_reset_state("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b0, 5'd0, CFG_RST, 10'h2aa);
    chk("post_rst_slot1", 32'(o_cur_slot), 32'd1);
    $display("post-reset first cen: cur_slot=%0d vld=%0d", o_cur_slot, o_eg_out_vld);
    run_steps(NS - 1);
    chk("lfo_round1", 32'(o_lfo_mod), 32'd0);
    run_steps(NS);
    chk("lfo_round2", 32'(o_lfo_mod), 32'd1);
    $display("after 2 rounds: lfo_mod=%0d", o_lfo_mod);
    run_steps(252 * NS);
    chk("lfo_round254", 32'(o_lfo_mod), 32'd127);
    $display("after 254 rounds: lfo_mod=%0d", o_lfo_mod);
    run_steps(2 * NS);
    chk("lfo_wrap", 32'(o_lfo_mod), 32'd0);
    $display("after 256 rounds: lfo_mod=%0d", o_lfo_mod);
    run_steps(3 * NS + 4);
    chk("lfo_round259", 32'(o_lfo_mod), 32'd1);

    // am_hold clears phase and divider: the next round alone must not step the LFO
    am_hold = 1'b1;
    @(posedge clk);
    #1;
    am_hold = 1'b0;
    chk("am_hold_lfo", 32'(o_lfo_mod), 32'd0);
    $display("am_hold pulse: lfo_mod=%0d", o_lfo_mod);
    run_steps(NS);
    chk("am_hold_div_clear", 32'(o_lfo_mod), 32'd0);
    run_steps(NS);
    chk("am_hold_restep", 32'(o_lfo_mod), 32'd1);
    $display("after am_hold + 2 rounds: lfo_mod=%0d", o_lfo_mod);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
